memory_bus_controller: RTL and testbench

- Sits directly downstream of the CPU core. It decodes the CPU's single address/data/RW bus into per-region device selects (ROM, VRAM, external RAM, WRAM, OAM, IO), owns the 127-byte HRAM, and muxes read data back to the core.
- Contains the OAM DMA engine triggered by a write to FF46. While DMA runs it owns the device bus and shields the CPU from every region except HRAM and FF46.

---
 rtl/memory_bus_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_memory_bus_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_controller.sv
// CPU-side memory bus decoder, HRAM owner, read-data mux and OAM DMA engine.
// DMA state table:
//   S_IDLE   | no transfer; CPU owns the device bus
//   S_START  | FF46 written, DMA_SLOT-cycle delay, CPU still unrestricted
//   S_ACTIVE | copying bytes, 4 phases per byte; CPU limited to HRAM/FF46
module memory_bus_controller #(
    parameter int DMA_LEN    = 160,
    parameter int DMA_SLOT   = 4,
    parameter int HRAM_DEPTH = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddress,
    input  logic [7:0]  cpuDataW,
    input  logic        cpuRW,
    output logic [7:0]  cpuDataR,
    output logic [15:0] busAddress,
    output logic [7:0]  busDataW,
    output logic        busWE,
    output logic        romSel,
    output logic        vramSel,
    output logic        eramSel,
    output logic        wramSel,
    output logic        oamSel,
    output logic        ioSel,
    input  logic [7:0]  romDataR,
    input  logic [7:0]  vramDataR,
    input  logic [7:0]  eramDataR,
    input  logic [7:0]  wramDataR,
    input  logic [7:0]  oamDataR,
    input  logic [7:0]  ioDataR,
    output logic        dmaActive
);
    localparam int SLOT_W = (DMA_SLOT > 1) ? $clog2(DMA_SLOT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_ACTIVE} dma_state_t;
    typedef enum logic [3:0] {
        RC_ZERO, RC_NONE, RC_ROM, RC_VRAM, RC_ERAM, RC_WRAM, RC_OAM, RC_IO, RC_HRAM, RC_DMAREG
    } region_t;

    function automatic region_t decode(input logic [15:0] a);
        if (a < 16'h8000)      return RC_ROM;
        else if (a < 16'hA000) return RC_VRAM;
        else if (a < 16'hC000) return RC_ERAM;
        else if (a < 16'hFE00) return RC_WRAM;
        else if (a < 16'hFEA0) return RC_OAM;
        else if (a < 16'hFF00) return RC_NONE;
        else if (a == 16'hFF46) return RC_DMAREG;
        else if (a < 16'hFF80 || a == 16'hFFFF) return RC_IO;
        else return RC_HRAM;
    endfunction

    function automatic logic [5:0] region_sel(input region_t r);
        case (r)
            RC_ROM:  return 6'b100000;
            RC_VRAM: return 6'b010000;
            RC_ERAM: return 6'b001000;
            RC_WRAM: return 6'b000100;
            RC_OAM:  return 6'b000010;
            RC_IO:   return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    dma_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        idx_q, idx_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        dma_src_q, dma_src_d;
    logic [7:0]        dma_byte_q, dma_byte_d;
    region_t           region_q, region_d;

    logic [7:0]  hram_q [HRAM_DEPTH];
    logic [7:0]  hram_rd_q;
    logic [6:0]  hram_idx;

    region_t     cpu_region, dma_src_region;
    logic        dma_owns, reg_write, hram_we;
    logic [7:0]  src_eff, dma_rd_data;
    logic [5:0]  bus_sel;

    assign cpu_region = decode(cpuAddress);
    assign dma_owns   = (state_q == S_ACTIVE);
    assign reg_write  = cpuRW && (cpu_region == RC_DMAREG);
    assign hram_we    = reset && cpuRW && (cpu_region == RC_HRAM);
    assign hram_idx   = cpuAddress[6:0];
    assign dmaActive  = (state_q != S_IDLE);

    // Sources at E0 and above fold onto WRAM; FE/FF pages are never read.
    assign src_eff        = (dma_src_q >= 8'hE0) ? (dma_src_q - 8'h20) : dma_src_q;
    assign dma_src_region = (dma_src_q >= 8'hFE) ? RC_NONE : decode({src_eff, 8'h00});

    assign region_d = (dma_owns && !(cpu_region inside {RC_HRAM, RC_DMAREG})) ? RC_NONE : cpu_region;

    always_comb begin
        bus_sel    = 6'b000000;
        busAddress = 16'h0000;
        busDataW   = 8'h00;
        busWE      = 1'b0;
        if (!reset) begin
            bus_sel = 6'b000000;
        end else if (dma_owns) begin
            busDataW = dma_byte_q;
            case (phase_q)
                2'd0: begin
                    busAddress = {src_eff, idx_q};
                    bus_sel    = region_sel(dma_src_region);
                end
                2'd1: busAddress = {src_eff, idx_q};
                2'd2: begin
                    busAddress = 16'hFE00 + {8'h00, idx_q};
                    bus_sel    = 6'b000010;
                    busWE      = 1'b1;
                end
                default: busAddress = 16'hFE00 + {8'h00, idx_q};
            endcase
        end else begin
            busAddress = (cpuAddress >= 16'hE000 && cpuAddress < 16'hFE00) ?
                         (cpuAddress - 16'h2000) : cpuAddress;
            busDataW   = cpuDataW;
            bus_sel    = region_sel(cpu_region);
            busWE      = cpuRW && (bus_sel != 6'b000000);
        end
    end

    assign {romSel, vramSel, eramSel, wramSel, oamSel, ioSel} = bus_sel;

    always_comb begin
        case (region_q)
            RC_ROM:    cpuDataR = romDataR;
            RC_VRAM:   cpuDataR = vramDataR;
            RC_ERAM:   cpuDataR = eramDataR;
            RC_WRAM:   cpuDataR = wramDataR;
            RC_OAM:    cpuDataR = oamDataR;
            RC_IO:     cpuDataR = ioDataR;
            RC_HRAM:   cpuDataR = hram_rd_q;
            RC_DMAREG: cpuDataR = dma_src_q;
            RC_ZERO:   cpuDataR = 8'h00;
            default:   cpuDataR = 8'hFF;
        endcase
    end

    always_comb begin
        case (dma_src_region)
            RC_ROM:  dma_rd_data = romDataR;
            RC_VRAM: dma_rd_data = vramDataR;
            RC_ERAM: dma_rd_data = eramDataR;
            RC_WRAM: dma_rd_data = wramDataR;
            default: dma_rd_data = 8'hFF;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        dma_src_d  = dma_src_q;
        dma_byte_d = dma_byte_q;
        if (reg_write) begin
            // A write always (re)starts the transfer, whatever state we are in.
            dma_src_d = cpuDataW;
            state_d   = S_START;
            slot_d    = SLOT_W'(DMA_SLOT - 1);
            idx_d     = 8'h00;
            phase_d   = 2'd0;
        end else begin
            case (state_q)
                S_START: begin
                    if (slot_q == '0) begin
                        state_d = S_ACTIVE;
                        idx_d   = 8'h00;
                        phase_d = 2'd0;
                    end else begin
                        slot_d = slot_q - 1'b1;
                    end
                end
                S_ACTIVE: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd1) dma_byte_d = dma_rd_data;
                    if (phase_q == 2'd3) begin
                        if (idx_q == 8'(DMA_LEN - 1)) begin
                            state_d = S_IDLE;
                            idx_d   = 8'h00;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            idx_q      <= 8'h00;
            phase_q    <= 2'd0;
            dma_src_q  <= 8'hFF;
            dma_byte_q <= 8'h00;
            region_q   <= RC_ZERO;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            dma_src_q  <= dma_src_d;
            dma_byte_q <= dma_byte_d;
            region_q   <= region_d;
        end
    end

    // HRAM survives reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (hram_we) hram_q[hram_idx] <= cpuDataW;
        if (cpu_region == RC_HRAM) hram_rd_q <= hram_q[hram_idx];
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Self-checking bench for memory_bus_controller: decode table, random CPU traffic
// against a range-based reference model, and DMA / restart / reset sequences.
module tb_memory_bus_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpuAddress;
    logic [7:0]  cpuDataW;
    logic        cpuRW;
    logic [7:0]  cpuDataR;
    logic [15:0] busAddress;
    logic [7:0]  busDataW;
    logic        busWE;
    logic        romSel, vramSel, eramSel, wramSel, oamSel, ioSel;
    logic [7:0]  romDataR, vramDataR, eramDataR, wramDataR, oamDataR, ioDataR;
    logic        dmaActive;

    memory_bus_controller dut (
        .clk(clk), .reset(reset), .cpuAddress(cpuAddress), .cpuDataW(cpuDataW), .cpuRW(cpuRW),
        .cpuDataR(cpuDataR), .busAddress(busAddress), .busDataW(busDataW), .busWE(busWE),
        .romSel(romSel), .vramSel(vramSel), .eramSel(eramSel), .wramSel(wramSel),
        .oamSel(oamSel), .ioSel(ioSel),
        .romDataR(romDataR), .vramDataR(vramDataR), .eramDataR(eramDataR),
        .wramDataR(wramDataR), .oamDataR(oamDataR), .ioDataR(ioDataR),
        .dmaActive(dmaActive)
    );

    always #5 clk = ~clk;

    // Device models: one-cycle latency, data derived from the address seen on the bus.
    always @(posedge clk) begin
        romDataR  <= busAddress[7:0] ^ 8'hA5;
        vramDataR <= busAddress[7:0] ^ 8'h3C;
        eramDataR <= busAddress[7:0] ^ 8'h69;
        wramDataR <= busAddress[7:0];
        oamDataR  <= busAddress[7:0] ^ 8'h0F;
        ioDataR   <= busAddress[7:0] ^ 8'hC3;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [5:0]  o_sel;
    logic [15:0] o_addr;
    logic        o_we, o_act;
    logic [7:0]  o_dw, o_rd;
    logic [7:0]  hram_m [0:126];
    logic [7:0]  ff46_m = 8'hFF;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic rw, input logic [7:0] wd);
        @(posedge clk);
        #1;
        cpuAddress = a;
        cpuRW      = rw;
        cpuDataW   = wd;
        @(negedge clk);
        o_sel  = {romSel, vramSel, eramSel, wramSel, oamSel, ioSel};
        o_addr = busAddress;
        o_we   = busWE;
        o_dw   = busDataW;
        o_rd   = cpuDataR;
        o_act  = dmaActive;
        cyc++;
    endtask

    // Reference model: region index 0..5 = rom,vram,eram,wram,oam,io; 6 hram; 7 FF46; -1 none.
    function automatic int m_region(input logic [15:0] a);
        int x = int'(a);
        if (x < 'h8000) return 0;
        if (x < 'hA000) return 1;
        if (x < 'hC000) return 2;
        if (x < 'hFE00) return 3;
        if (x < 'hFEA0) return 4;
        if (x < 'hFF00) return -1;
        if (x == 'hFF46) return 7;
        if (x < 'hFF80 || x == 'hFFFF) return 5;
        return 6;
    endfunction

    function automatic logic [5:0] m_sel(input logic [15:0] a);
        int r = m_region(a);
        if (r >= 0 && r <= 5) return 6'b100000 >> r;
        return 6'b000000;
    endfunction

    function automatic logic [15:0] m_baddr(input logic [15:0] a);
        if (int'(a) >= 'hE000 && int'(a) < 'hFE00) return a - 16'd8192;
        return a;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [15:0] a);
        int r = m_region(a);
        logic [7:0] lo = a[7:0];
        case (r)
            0: return lo ^ 8'hA5;
            1: return lo ^ 8'h3C;
            2: return lo ^ 8'h69;
            3: return lo;
            4: return lo ^ 8'h0F;
            5: return lo ^ 8'hC3;
            6: return hram_m[int'(a) - 'hFF80];
            7: return ff46_m;
            default: return 8'hFF;
        endcase
    endfunction

    typedef struct {
        logic [15:0] addr; logic rw; logic [7:0] wd;
        logic [5:0] sel; logic [15:0] baddr; logic we; logic chk_r; logic [7:0] rd;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic        prev_chk;
        logic [7:0]  prev_rd;
        int n_oam, n_src, bad_oam, bad_src, bad_gap, act_cnt, rom_seen, first_oam, last_oam;
        int restart_k, oam_idx;
        logic restarted, pending, found;

        tbl.push_back('{16'hC15A, 1'b0, 8'h00, 6'b000100, 16'hC15A, 1'b0, 1'b1, 8'h5A});
        tbl.push_back('{16'hE123, 1'b0, 8'h00, 6'b000100, 16'hC123, 1'b0, 1'b1, 8'h23});
        tbl.push_back('{16'hFF80, 1'b1, 8'h3C, 6'b000000, 16'hFF80, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{16'hFF80, 1'b0, 8'h00, 6'b000000, 16'hFF80, 1'b0, 1'b1, 8'h3C});
        tbl.push_back('{16'hFEA5, 1'b0, 8'h00, 6'b000000, 16'hFEA5, 1'b0, 1'b1, 8'hFF});
        tbl.push_back('{16'h0100, 1'b0, 8'h00, 6'b100000, 16'h0100, 1'b0, 1'b1, 8'hA5});
        tbl.push_back('{16'h8042, 1'b0, 8'h00, 6'b010000, 16'h8042, 1'b0, 1'b1, 8'h7E});
        tbl.push_back('{16'hA0FF, 1'b0, 8'h00, 6'b001000, 16'hA0FF, 1'b0, 1'b1, 8'h96});
        tbl.push_back('{16'hFE9F, 1'b0, 8'h00, 6'b000010, 16'hFE9F, 1'b0, 1'b1, 8'h90});
        tbl.push_back('{16'hFF00, 1'b0, 8'h00, 6'b000001, 16'hFF00, 1'b0, 1'b1, 8'hC3});
        tbl.push_back('{16'hFFFF, 1'b0, 8'h00, 6'b000001, 16'hFFFF, 1'b0, 1'b1, 8'h3C});
        tbl.push_back('{16'hC000, 1'b1, 8'h55, 6'b000100, 16'hC000, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{16'hFDFF, 1'b0, 8'h00, 6'b000100, 16'hDDFF, 1'b0, 1'b1, 8'hFF});
        tbl.push_back('{16'hFF7F, 1'b0, 8'h00, 6'b000001, 16'hFF7F, 1'b0, 1'b1, 8'hBC});
        tbl.push_back('{16'hFEFF, 1'b0, 8'h00, 6'b000000, 16'hFEFF, 1'b0, 1'b1, 8'hFF});
        tbl.push_back('{16'hFF46, 1'b0, 8'h00, 6'b000000, 16'hFF46, 1'b0, 1'b1, 8'hFF});
        tbl.push_back('{16'h7FFF, 1'b1, 8'h12, 6'b100000, 16'h7FFF, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{16'hFFFE, 1'b1, 8'hA7, 6'b000000, 16'hFFFE, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{16'hFFFE, 1'b0, 8'h00, 6'b000000, 16'hFFFE, 1'b0, 1'b1, 8'hA7});
        tbl.push_back('{16'hFEA0, 1'b1, 8'h33, 6'b000000, 16'hFEA0, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{16'hFF47, 1'b0, 8'h00, 6'b000001, 16'hFF47, 1'b0, 1'b1, 8'h84});

        // Reset state, with a CPU write presented to prove the outputs are gated.
        reset = 1'b1; cpuAddress = 16'hC000; cpuRW = 1'b1; cpuDataW = 8'hAA;
        #2 reset = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_sel", {romSel, vramSel, eramSel, wramSel, oamSel, ioSel}, 6'b0);
        chk("rst_we", busWE, 1'b0);
        chk("rst_act", dmaActive, 1'b0);
        chk("rst_addr", busAddress, 16'h0000);
        chk("rst_dw", busDataW, 8'h00);
        chk("rst_rd", cpuDataR, 8'h00);
        @(posedge clk); #1 reset = 1'b1; cpuRW = 1'b0;

        for (int i = 0; i < 127; i++) begin
            step(16'hFF80 + 16'(i), 1'b1, 8'(i * 7 + 3));
            hram_m[i] = 8'(i * 7 + 3);
        end

        prev_chk = 1'b0; prev_rd = 8'h00;
        foreach (tbl[i]) begin
            step(tbl[i].addr, tbl[i].rw, tbl[i].wd);
            chk($sformatf("tbl%0d_sel", i), o_sel, tbl[i].sel);
            chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].baddr);
            chk($sformatf("tbl%0d_we", i), o_we, tbl[i].we);
            if (tbl[i].we) chk($sformatf("tbl%0d_dw", i), o_dw, tbl[i].wd);
            if (prev_chk) chk($sformatf("tbl%0d_rd", i - 1), o_rd, prev_rd);
            prev_chk = tbl[i].chk_r; prev_rd = tbl[i].rd;
            if (tbl[i].rw && m_region(tbl[i].addr) == 6) hram_m[int'(tbl[i].addr) - 'hFF80] = tbl[i].wd;
        end
        step(16'hFF82, 1'b0, 8'h00);
        if (prev_chk) chk("tbl_last_rd", o_rd, prev_rd);

        // Random CPU traffic with no DMA running.
        prev_chk = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a; logic rw; logic [7:0] wd; int pick;
            pick = int'($urandom_range(0, 7));
            a  = 16'($urandom_range(0, 65535));
            if (pick < 2) a = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (pick == 2) a = 16'hFEA0 + 16'($urandom_range(0, 95));
            if (a == 16'hFF46) a = 16'hFF47;
            rw = 1'($urandom_range(0, 1));
            wd = 8'($urandom_range(0, 255));
            step(a, rw, wd);
            chk("rnd_sel", o_sel, m_sel(a));
            chk("rnd_addr", o_addr, m_baddr(a));
            chk("rnd_we", o_we, rw && (m_sel(a) != 6'b0));
            if (prev_chk) chk("rnd_rd", o_rd, prev_rd);
            prev_chk = !rw;
            prev_rd  = m_rdata(a);
            if (rw && m_region(a) == 6) hram_m[int'(a) - 'hFF80] = wd;
        end

        // Full DMA from C1 with CPU blocking probes during ACTIVE.
        step(16'hFF46, 1'b1, 8'hC1); ff46_m = 8'hC1;
        n_oam = 0; n_src = 0; bad_oam = 0; bad_src = 0; bad_gap = 0;
        act_cnt = 0; rom_seen = 0; first_oam = -1; last_oam = -1;
        for (int k = 1; k <= 700; k++) begin
            case (k)
                100: step(16'h0100, 1'b0, 8'h00);
                101: step(16'hFF81, 1'b1, 8'h77);
                102: step(16'hFF81, 1'b0, 8'h00);
                103: step(16'hC000, 1'b1, 8'h99);
                default: step(16'hFF82, 1'b0, 8'h00);
            endcase
            if (k == 101) chk("dma_block_rd", o_rd, 8'hFF);
            if (k == 103) chk("dma_hram_rd", o_rd, 8'h77);
            if (o_act) act_cnt++;
            if (o_sel[5]) rom_seen++;
            if (o_we) begin
                if (!(o_sel == 6'b000010 && o_addr == (16'hFE00 + 16'(n_oam)) && o_dw == 8'(n_oam)))
                    bad_oam++;
                if (first_oam < 0) first_oam = k;
                else if (k - last_oam != 4) bad_gap++;
                last_oam = k;
                n_oam++;
            end
            if (o_sel == 6'b000100) begin
                if (o_addr != 16'hC100 + 16'(n_src)) bad_src++;
                n_src++;
            end
        end
        hram_m[1] = 8'h77;
        chk("dma_oam_count", n_oam, 160);
        chk("dma_oam_bad", bad_oam, 0);
        chk("dma_oam_gap", bad_gap, 0);
        chk("dma_first_oam_cycle", first_oam, 7);
        chk("dma_src_count", n_src, 160);
        chk("dma_src_bad", bad_src, 0);
        chk("dma_active_cycles", act_cnt, 644);
        chk("dma_rom_sel", rom_seen, 0);

        // Restart with an echo source after idx 49 has been written.
        step(16'hFF46, 1'b1, 8'hC0);
        n_oam = 0; n_src = 0; bad_oam = 0; bad_src = 0; act_cnt = 0;
        oam_idx = 0; restarted = 1'b0; pending = 1'b0; restart_k = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (pending && !restarted) begin
                step(16'hFF46, 1'b1, 8'hE2);
                restarted = 1'b1; restart_k = k; oam_idx = 0;
            end else begin
                step(16'hFF82, 1'b0, 8'h00);
            end
            if (o_act) act_cnt++;
            if (o_we) begin
                if (!(o_sel == 6'b000010 && o_addr == (16'hFE00 + 16'(oam_idx)) && o_dw == 8'(oam_idx)))
                    bad_oam++;
                if (!restarted && o_addr == 16'hFE31) pending = 1'b1;
                oam_idx++;
                n_oam++;
            end
            if (restarted && o_sel == 6'b000100) begin
                if (o_addr != 16'hC200 + 16'(n_src)) bad_src++;
                n_src++;
            end
        end
        ff46_m = 8'hE2;
        chk("rst_dma_restarted", restarted, 1'b1);
        chk("rst_dma_oam_total", n_oam, 210);
        chk("rst_dma_oam_bad", bad_oam, 0);
        chk("rst_dma_src_count", n_src, 160);
        chk("rst_dma_src_bad", bad_src, 0);
        chk("rst_dma_active", act_cnt, restart_k + 644);
        step(16'hFF46, 1'b0, 8'h00);
        step(16'hFF82, 1'b0, 8'h00);
        chk("rst_dma_ff46_rd", o_rd, 8'hE2);

        // Reset in the middle of a transfer.
        step(16'hFF46, 1'b1, 8'hC1);
        found = 1'b0;
        for (int k = 0; k < 800 && !found; k++) begin
            step(16'hFF82, 1'b0, 8'h00);
            if (o_we && o_addr == 16'hFE50) found = 1'b1;
        end
        chk("mid_reset_reached_idx80", found, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("mid_reset_act", dmaActive, 1'b0);
        chk("mid_reset_oam", oamSel, 1'b0);
        chk("mid_reset_we", busWE, 1'b0);
        chk("mid_reset_rd", cpuDataR, 8'h00);
        n_oam = 0; act_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step(16'hFF81, 1'b0, 8'h00);
            if (o_sel[1]) n_oam++;
            if (o_act) act_cnt++;
        end
        @(posedge clk); #1 reset = 1'b1;
        for (int k = 0; k < 700; k++) begin
            step(16'hFF82, 1'b0, 8'h00);
            if (o_sel[1]) n_oam++;
            if (o_act) act_cnt++;
        end
        chk("post_reset_oam", n_oam, 0);
        chk("post_reset_act", act_cnt, 0);
        step(16'hFF46, 1'b0, 8'h00);
        step(16'hFF80, 1'b0, 8'h00);
        chk("post_reset_ff46", o_rd, 8'hFF);
        step(16'hFF81, 1'b0, 8'h00);
        chk("post_reset_hram0", o_rd, hram_m[0]);
        step(16'hFF82, 1'b0, 8'h00);
        chk("post_reset_hram1", o_rd, hram_m[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
